// File: rtl/credit_fir_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : credit_fir_pkg
//  Purpose  : Shared constants and helpers for the credit-based FIR wrapper.
//  Revision : 1.0
// ============================================================================
package credit_fir_pkg;

    localparam int CORE_LATENCY = 5;
    localparam int NUM_TAPS     = 4;
    localparam int GUARD_BITS   = 3;
    localparam int TAP_COEF [NUM_TAPS] = '{1, 2, 2, 1};

    // Counter must represent 0 .. 2**fifo_addr inclusive.
    function automatic int credit_cnt_width(input int fifo_addr);
        return $clog2((1 << fifo_addr) + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/credit_sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : credit_sync_fifo
//  Purpose  : Synchronous FIFO with registered read port and full/empty flags.
//  Revision : 1.0
// ============================================================================
module credit_sync_fifo #(
    parameter int    DATA_WIDTH = 16,
    parameter int    FIFO_ADDR  = 4,
    parameter string FIFO_TYPE  = "BRAM"
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  i_wr_en,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    input  logic                  i_rd_en,
    output logic [DATA_WIDTH-1:0] o_rd_data,
    output logic                  o_full,
    output logic                  o_empty
);

    localparam int c_depth = 1 << FIFO_ADDR;

    logic [FIFO_ADDR:0]      wr_ptr_q, wr_ptr_d;
    logic [FIFO_ADDR:0]      rd_ptr_q, rd_ptr_d;
    logic [DATA_WIDTH-1:0]   rd_data_q;
    logic                    w_wr_fire;
    logic                    w_rd_fire;
    logic [FIFO_ADDR-1:0]    w_wr_addr;
    logic [FIFO_ADDR-1:0]    w_rd_addr;

    // Extra pointer MSB distinguishes full from empty when addresses match.
    assign o_full    = (wr_ptr_q[FIFO_ADDR] != rd_ptr_q[FIFO_ADDR]) &&
                       (wr_ptr_q[FIFO_ADDR-1:0] == rd_ptr_q[FIFO_ADDR-1:0]);
    assign o_empty   = (wr_ptr_q == rd_ptr_q);
    assign w_wr_fire = i_wr_en && !o_full;
    assign w_rd_fire = i_rd_en && !o_empty;
    assign w_wr_addr = wr_ptr_q[FIFO_ADDR-1:0];
    assign w_rd_addr = rd_ptr_q[FIFO_ADDR-1:0];
    assign o_rd_data = rd_data_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (w_wr_fire) begin
            wr_ptr_d = wr_ptr_q + (FIFO_ADDR+1)'(1);
        end
        if (w_rd_fire) begin
            rd_ptr_d = rd_ptr_q + (FIFO_ADDR+1)'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    generate
        if (FIFO_TYPE == "LUTRAM") begin : g_lutram
            (* ram_style = "distributed" *) logic [DATA_WIDTH-1:0] mem_q [c_depth];
            logic [DATA_WIDTH-1:0] w_rd_word;

            assign w_rd_word = mem_q[w_rd_addr];

            always_ff @(posedge clock) begin
                if (w_wr_fire) begin
                    mem_q[w_wr_addr] <= i_wr_data;
                end
                if (w_rd_fire) begin
                    rd_data_q <= w_rd_word;
                end
            end
        end else begin : g_bram
            (* ram_style = "block" *) logic [DATA_WIDTH-1:0] mem_q [c_depth];

            always_ff @(posedge clock) begin
                if (w_wr_fire) begin
                    mem_q[w_wr_addr] <= i_wr_data;
                end
                if (w_rd_fire) begin
                    rd_data_q <= mem_q[w_rd_addr];
                end
            end
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/credit_fir_wrapper.sv
`default_nettype none
// ============================================================================
//  Module   : credit_fir_wrapper
//  Purpose  : Credit-based latency-insensitive wrapper around a 4-tap FIR.
//  Revision : 1.0
// ============================================================================
module credit_fir_wrapper
    import credit_fir_pkg::*;
#(
    parameter int    DATA_WIDTH = 16,
    parameter int    FIFO_ADDR  = 4,
    parameter string FIFO_TYPE  = "BRAM"
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic signed [DATA_WIDTH-1:0] i_data,
    input  logic                         i_valid,
    output logic                         o_increment_count,
    output logic signed [DATA_WIDTH-1:0] o_data,
    output logic                         o_valid,
    input  logic                         i_increment_count
);

    localparam int                c_cnt_w      = credit_cnt_width(FIFO_ADDR);
    localparam int                c_y_w        = DATA_WIDTH + GUARD_BITS;
    localparam logic [c_cnt_w-1:0] c_credit_max = c_cnt_w'(1 << FIFO_ADDR);

    logic                         w_fifo_full;
    logic                         w_fifo_empty;
    logic [DATA_WIDTH-1:0]        w_fifo_rd_data;
    logic                         w_pop;
    logic [c_y_w-1:0]             w_prod [NUM_TAPS];
    logic                         w_unused_y_msbs;

    logic [c_cnt_w-1:0]           credit_q, credit_d;
    logic                         inc_out_q, inc_out_d;
    logic [CORE_LATENCY-1:0]      valid_q, valid_d;
    logic signed [DATA_WIDTH-1:0] tap_q [NUM_TAPS];
    logic signed [DATA_WIDTH-1:0] tap_d [NUM_TAPS];
    logic [c_y_w-1:0]             psum_lo_q, psum_lo_d;
    logic [c_y_w-1:0]             psum_hi_q, psum_hi_d;
    logic [c_y_w-1:0]             y_q, y_d;
    logic signed [DATA_WIDTH-1:0] data_out_q, data_out_d;

    credit_sync_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .FIFO_ADDR  (FIFO_ADDR),
        .FIFO_TYPE  (FIFO_TYPE)
    ) u_in_fifo (
        .clock     (clock),
        .reset     (reset),
        .i_wr_en   (i_valid),
        .i_wr_data (i_data),
        .i_rd_en   (w_pop),
        .o_rd_data (w_fifo_rd_data),
        .o_full    (w_fifo_full),
        .o_empty   (w_fifo_empty)
    );

    // Credit is taken at pop time so every in-flight word already owns a slot downstream.
    assign w_pop = !w_fifo_empty && (credit_q != '0);

    always_comb begin
        credit_d = credit_q;
        case ({w_pop, i_increment_count})
            2'b10: credit_d = credit_q - c_cnt_w'(1);
            2'b01: begin
                if (credit_q != c_credit_max) begin
                    credit_d = credit_q + c_cnt_w'(1);
                end
            end
            default: credit_d = credit_q;
        endcase
    end

    generate
        for (genvar gi = 0; gi < NUM_TAPS; gi++) begin : g_prod
            localparam logic [c_y_w-1:0] c_coef = c_y_w'(TAP_COEF[gi]);
            assign w_prod[gi] = {{GUARD_BITS{tap_q[gi][DATA_WIDTH-1]}}, tap_q[gi]} * c_coef;
        end
    endgenerate

    // Stages: 1 FIFO read, 2 tap shift, 3 partial sums, 4 full sum, 5 output.
    always_comb begin
        inc_out_d = w_pop;
        valid_d   = {valid_q[CORE_LATENCY-2:0], w_pop};
        tap_d     = tap_q;
        if (valid_q[0]) begin
            tap_d[0] = w_fifo_rd_data;
            for (int i = 1; i < NUM_TAPS; i++) begin
                tap_d[i] = tap_q[i-1];
            end
        end
        psum_lo_d  = valid_q[1] ? (w_prod[0] + w_prod[1]) : psum_lo_q;
        psum_hi_d  = valid_q[1] ? (w_prod[2] + w_prod[3]) : psum_hi_q;
        y_d        = valid_q[2] ? (psum_lo_q + psum_hi_q) : y_q;
        data_out_d = valid_q[3] ? y_q[DATA_WIDTH-1:0] : data_out_q;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            credit_q   <= c_credit_max;
            inc_out_q  <= 1'b0;
            valid_q    <= '0;
            for (int i = 0; i < NUM_TAPS; i++) begin
                tap_q[i] <= '0;
            end
            psum_lo_q  <= '0;
            psum_hi_q  <= '0;
            y_q        <= '0;
            data_out_q <= '0;
        end else begin
            credit_q   <= credit_d;
            inc_out_q  <= inc_out_d;
            valid_q    <= valid_d;
            tap_q      <= tap_d;
            psum_lo_q  <= psum_lo_d;
            psum_hi_q  <= psum_hi_d;
            y_q        <= y_d;
            data_out_q <= data_out_d;
        end
    end

    // Guard bits only matter for the internal sum; the output wraps to DATA_WIDTH.
    assign w_unused_y_msbs   = ^y_q[c_y_w-1:DATA_WIDTH];

    assign o_increment_count = inc_out_q;
    assign o_valid           = valid_q[CORE_LATENCY-1];
    assign o_data            = data_out_q;

    a_no_write_when_full: assert property (
        @(posedge clock) disable iff (reset) !(i_valid && w_fifo_full));

    a_no_credit_overflow: assert property (
        @(posedge clock) disable iff (reset)
        !(i_increment_count && !w_pop && (credit_q == c_credit_max)));

endmodule
`default_nettype wire

// File: tb/tb_credit_fir_wrapper.sv
`default_nettype none
// ============================================================================
//  Module   : tb_credit_fir_wrapper
//  Purpose  : Self-checking bench: behavioural credit/FIR model plus literal pins.
//  Revision : 1.0
// ============================================================================
module tb_credit_fir_wrapper;

    localparam int DW    = 16;
    localparam int FA    = 2;
    localparam int DEPTH = 1 << FA;
    localparam int DW8   = 8;
    localparam int FA8   = 4;

    logic                  clock = 1'b0;
    logic                  reset = 1'b1;
    logic signed [DW-1:0]  i_data = '0;
    logic                  i_valid = 1'b0;
    logic                  i_increment_count = 1'b0;
    logic                  o_increment_count;
    logic signed [DW-1:0]  o_data;
    logic                  o_valid;

    logic signed [DW8-1:0] i_data8 = '0;
    logic                  i_valid8 = 1'b0;
    logic                  i_increment_count8 = 1'b0;
    logic                  o_increment_count8;
    logic signed [DW8-1:0] o_data8;
    logic                  o_valid8;

    always #5 clock = ~clock;

    credit_fir_wrapper #(.DATA_WIDTH(DW), .FIFO_ADDR(FA), .FIFO_TYPE("BRAM")) dut (
        .clock(clock), .reset(reset), .i_data(i_data), .i_valid(i_valid),
        .o_increment_count(o_increment_count), .o_data(o_data), .o_valid(o_valid),
        .i_increment_count(i_increment_count));

    credit_fir_wrapper #(.DATA_WIDTH(DW8), .FIFO_ADDR(FA8), .FIFO_TYPE("LUTRAM")) dut8 (
        .clock(clock), .reset(reset), .i_data(i_data8), .i_valid(i_valid8),
        .o_increment_count(o_increment_count8), .o_data(o_data8), .o_valid(o_valid8),
        .i_increment_count(i_increment_count8));

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int wrapw(input int v, input int w);
        return (v <<< (32 - w)) >>> (32 - w);
    endfunction

    function automatic int qat(input int q[$], input int idx);
        if (idx < q.size()) return q[idx];
        return -99999;
    endfunction

    task automatic chk_list(input string name, input int q[$], input int e[$]);
        chk({name, "_count"}, q.size(), e.size());
        for (int i = 0; i < e.size(); i++) begin
            chk($sformatf("%s[%0d]", name, i), qat(q, i), e[i]);
        end
    endtask

    // ---------------- behavioural model of the main DUT ----------------
    int q_fifo[$];
    int credit_m;
    int hist[4];
    int k;
    bit ev[8];
    bit ei[8];
    int ed[8];
    int hold;

    initial begin
        forever begin
            @(posedge clock or posedge reset);
            if (reset) begin
                q_fifo.delete();
                credit_m = DEPTH;
                for (int i = 0; i < 4; i++) hist[i] = 0;
                for (int i = 0; i < 8; i++) begin ev[i] = 0; ei[i] = 0; ed[i] = 0; end
                hold = 0;
                k = 0;
            end else begin
                bit pop;
                int y;
                pop = (q_fifo.size() > 0) && (credit_m > 0);
                if (pop) begin
                    hist[3] = hist[2];
                    hist[2] = hist[1];
                    hist[1] = hist[0];
                    hist[0] = q_fifo.pop_front();
                    y = hist[0] + 2 * hist[1] + 2 * hist[2] + hist[3];
                    ei[(k + 1) % 8] = 1;
                    ev[(k + 5) % 8] = 1;
                    ed[(k + 5) % 8] = wrapw(y, DW);
                end
                if (pop && !i_increment_count) credit_m--;
                else if (!pop && i_increment_count && credit_m < DEPTH) credit_m++;
                if (i_valid && q_fifo.size() < DEPTH) q_fifo.push_back(int'(i_data));
                k++;
            end
        end
    end

    // ---------------- per-cycle compare and output capture ----------------
    int out_val[$];
    int out_cyc[$];
    int inc_cyc[$];
    int out8_val[$];
    int out8_cyc[$];

    initial begin
        forever begin
            int s;
            @(negedge clock);
            #1;
            if (reset) begin
                chk("rst_o_valid", int'(o_valid), 0);
                chk("rst_o_increment_count", int'(o_increment_count), 0);
                chk("rst_o_data", int'(o_data), 0);
            end else begin
                s = k % 8;
                chk("o_valid", int'(o_valid), int'(ev[s]));
                chk("o_increment_count", int'(o_increment_count), int'(ei[s]));
                if (ev[s]) hold = ed[s];
                chk("o_data", int'(o_data), hold);
                ev[s] = 0;
                ei[s] = 0;
                if (o_valid) begin out_val.push_back(int'(o_data)); out_cyc.push_back(k); end
                if (o_increment_count) inc_cyc.push_back(k);
            end
            if (o_valid8) begin out8_val.push_back(int'(o_data8)); out8_cyc.push_back(k); end
        end
    end

    // ---------------- stimulus ----------------
    int up_credit;
    int ds_pending;
    int up8;
    int sent_cnt;

    task automatic clear_logs();
        out_val.delete(); out_cyc.delete(); inc_cyc.delete();
        out8_val.delete(); out8_cyc.delete();
        sent_cnt = 0;
    endtask

    task automatic apply_reset(input int cycles);
        @(negedge clock);
        reset = 1'b1;
        i_valid = 0; i_increment_count = 0; i_data = '0;
        i_valid8 = 0; i_increment_count8 = 0; i_data8 = '0;
        up_credit = DEPTH; ds_pending = 0; up8 = 1 << FA8;
        repeat (cycles) @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic step(input bit send, input int d, input int ret_pct, input bit send8);
        @(negedge clock);
        if (o_increment_count) up_credit++;
        if (o_valid) ds_pending++;
        if (o_increment_count8) up8++;
        i_valid = send && (up_credit > 0);
        if (i_valid) begin up_credit--; sent_cnt++; end
        i_data = DW'(d);
        i_increment_count = 0;
        if (ds_pending > 0 && (int'($urandom_range(99)) < ret_pct)) begin
            i_increment_count = 1;
            ds_pending--;
        end
        i_valid8 = send8 && (up8 > 0);
        if (i_valid8) up8--;
        i_data8 = 8'sd100;
        i_increment_count8 = o_valid8;
    endtask

    task automatic idle(input int n, input int ret_pct);
        repeat (n) step(0, 0, ret_pct, 0);
    endtask

    initial begin
        int e[$];
        int ks;
        bit gap;

        // Latency and impulse response
        apply_reset(3);
        clear_logs();
        step(1, 1, 100, 0);
        ks = k;
        repeat (4) step(1, 0, 100, 0);
        idle(15, 100);
        e = {1, 2, 2, 1, 0};
        chk_list("impulse", out_val, e);
        chk("latency_out", qat(out_cyc, 0) - ks, 6);
        chk("latency_credit", qat(inc_cyc, 0) - ks, 2);

        // Step response
        apply_reset(2);
        clear_logs();
        repeat (6) step(1, 3, 100, 0);
        idle(20, 100);
        e = {3, 9, 15, 18, 18, 18};
        chk_list("step", out_val, e);

        // Downstream credit exhaustion
        apply_reset(2);
        clear_logs();
        for (int i = 1; i <= 4; i++) step(1, 10 * i, 0, 0);
        idle(15, 0);
        chk("exhaust_outs", out_val.size(), 4);
        chk("exhaust_incs", inc_cyc.size(), 4);
        for (int i = 5; i <= 8; i++) step(1, 10 * i, 0, 0);
        idle(15, 0);
        chk("exhaust_stall_outs", out_val.size(), 4);
        chk("exhaust_stall_incs", inc_cyc.size(), 4);
        idle(2, 100);
        idle(15, 0);
        e = {10, 40, 90, 150, 210, 270};
        chk_list("exhaust_resume", out_val, e);
        chk("exhaust_resume_incs", inc_cyc.size(), 6);

        // Randomised traffic against the model
        apply_reset(2);
        clear_logs();
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(99) < 60), int'($urandom_range(65535)) - 32768, 60, 0);
        end
        idle(25, 100);
        chk("random_count", out_val.size(), sent_cnt);

        // Reset with 3 words buffered and 2 in flight
        apply_reset(2);
        clear_logs();
        for (int i = 0; i < 7; i++) step(1, 100 + i, 0, 0);
        chk("midrst_sent", sent_cnt, 7);
        apply_reset(2);
        clear_logs();
        idle(8, 0);
        chk("midrst_no_outs", out_val.size(), 0);
        chk("midrst_no_incs", inc_cyc.size(), 0);
        step(1, 5, 0, 0);
        repeat (3) step(1, 0, 0, 0);
        idle(15, 0);
        e = {5, 10, 10, 5};
        chk_list("midrst_after", out_val, e);
        chk("midrst_after_incs", inc_cyc.size(), 4);

        // 8-bit wrap and gap-free streaming on the deep instance
        apply_reset(2);
        clear_logs();
        step(0, 0, 0, 1);
        ks = k;
        repeat (24) step(0, 0, 0, 1);
        idle(12, 0);
        e = {100, 44, -12, 88, 88};
        for (int i = 5; i < 25; i++) e.push_back(88);
        chk_list("wrap8", out8_val, e);
        chk("wrap8_latency", qat(out8_cyc, 0) - ks, 6);
        gap = 0;
        for (int i = 1; i < out8_cyc.size(); i++) begin
            if (out8_cyc[i] != out8_cyc[i-1] + 1) gap = 1;
        end
        chk("stream8_gap_free", int'(gap), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/credit_fir_wrapper.md
Name: credit_fir_wrapper

Overview:
- Credit-based latency-insensitive wrapper around a fixed 4-tap FIR datapath.
- Upstream may send a word only while it holds a credit. Each word the wrapper drains from its input FIFO is returned to upstream as a one-cycle credit pulse.
- On the output side the wrapper keeps a credit counter for the downstream buffer and never emits a word without a credit.
- Used as the "credit" variant of the FIR link wrappers.

Parameters:
- DATA_WIDTH, 16: signed sample width, input and output.
- FIFO_ADDR, 4: input FIFO depth is 2**FIFO_ADDR. The downstream buffer is also assumed to hold 2**FIFO_ADDR words.
- FIFO_TYPE, "BRAM": memory style, "BRAM" or "LUTRAM". Inference style only; cycle behaviour is identical for both.

Ports:
- clock  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- i_data  in  DATA_WIDTH  signed input sample.
- i_valid  in  1  i_data is valid this cycle; a write into the input FIFO.
- o_increment_count  out  1  one-cycle credit return to upstream.
- o_data  out  DATA_WIDTH  signed FIR output sample.
- o_valid  out  1  o_data is valid this cycle.
- i_increment_count  in  1  one-cycle credit return from downstream.

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - FIFO empty; tap history = 0; pipeline valids = 0.
  - credit = 2**FIFO_ADDR; credit counter is FIFO_ADDR+1 bits.
  - o_valid = 0, o_data = 0, o_increment_count = 0.
- Write: i_valid=1 at cycle t stores i_data. The FIFO is non-empty from t+1.
- Write while full: protocol violation. The word is dropped, state is unchanged, and a simulation assertion fires.
- Pop: at cycle P, pop the FIFO head when (FIFO non-empty) && (credit > 0).
- Credit reservation: the credit is consumed at pop time, so in-flight words are always covered.
- Credit return to upstream: o_increment_count = 1 in cycle P+1, registered, exactly one pulse per popped word.
- Output credit counter, per cycle:
  - pop only: credit -1.
  - i_increment_count only: credit +1.
  - both in the same cycle: unchanged.
  - An increment that would exceed 2**FIFO_ADDR is a protocol violation: saturate and assert.
- FIR:
  - Taps hold the last four popped samples x0 (newest) to x3, updated only on pop. Each pop is one transaction; idle cycles do not shift history.
  - y = x0 + 2*x1 + 2*x2 + x3, computed at full precision (DATA_WIDTH+3 bits).
  - o_data = low DATA_WIDTH bits of y (two's-complement wrap, no saturation).
- Latency:
  - The FIR is a non-stalling, fixed 5-stage pipeline with a valid bit per stage.
  - The word popped at P appears with o_valid=1 at P+5.
  - Minimum i_valid-to-o_valid latency is 6 cycles.
- Throughput: one pop, and one output, per cycle when data and credit are available.
- o_data holds its last value while o_valid=0.
- Back-to-back pops produce back-to-back outputs in pop order.
- Reset mid-operation drops all in-flight and buffered words, clears history, and restores full credit.

Decomposition:
- Package credit_fir_pkg:
  - CORE_LATENCY=5.
  - Tap coefficients {1,2,2,1}.
  - Helper for the credit-counter width ($clog2(2**FIFO_ADDR+1)).
- Sub-module credit_sync_fifo: synchronous FIFO with depth 2**FIFO_ADDR and FIFO_TYPE memory style, plus full/empty flags.
- The FIR pipeline and credit logic live in the top module.

Test Plan:
- Latency: reset, with downstream credits always returned. i_valid=1 with data 1 at cycle 0 -> o_increment_count=1 at cycle 2; o_valid=1 with o_data=1 at cycle 6.
- Impulse: send 1,0,0,0,0 -> outputs 1,2,2,1,0. Step: send 3 repeated -> outputs 3,9,15,18,18,...
- Credit exhaustion: FIFO_ADDR=2, i_increment_count held 0, send 4 words -> exactly 4 outputs, then o_valid stays 0. Resend 4 words -> FIFO fills, no pops. Two i_increment_count pulses -> exactly 2 more outputs and 2 more o_increment_count pulses.
- Simultaneous events: pop and i_increment_count in the same cycle -> credit unchanged. Sustained streaming with 1:1 returns -> one output per cycle, no gaps.
- Wrap: DATA_WIDTH=8, send 100 repeated -> outputs 100, 44, -12, 88, 88.
- Reset mid-stream: assert reset with 3 words buffered and 2 in flight -> o_valid=0 immediately and no further outputs. After release, input 5 -> output 5 (history cleared), and 2**FIFO_ADDR words are accepted without any returned credits.
